gpio_in_cond: RTL and testbench

//  Input conditioner directly upstream of the gpio register block.

---
 rtl/gpio_in_cond.sv | 206 ++++++++++++++++++++
 tb/tb_gpio_in_cond.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_cond.sv
// ---------------------------------------------------------------------------
// gpio_in_cond
//   Conditions the raw GPIO pads before the gpio register block sees them.
//   Each bit is synchronised with two flops and then debounced. A new level
//   is accepted only after it has been stable for DB_CYCLES synced cycles.
//   Level changes are latched into sticky per-bit status bits when the
//   matching rise/fall enable is set, and a maskable interrupt is raised.
//   The block has its own small register window on the shared bus.
//
//   Ports
//     clk      in   1      system clock, posedge
//     rst      in   1      asynchronous active-high reset
//     pins_in  in   WIDTH  raw asynchronous pad inputs
//     addr     in   16     bus address, only [3:0] decoded
//     wdata    in   16     bus write data
//     we       in   1      single-cycle write strobe (externally decoded)
//     rdata    out  16     read data, combinational from addr[3:0]
//     gpio_in  out  WIDTH  debounced level
//     irq      out  1      |(status & mask)
//
//   Register window (addr[3:0])
//     0x0 LEVEL     RO   debounced level
//     0x4 STATUS    W1C  sticky edge events
//     0x8 IRQ_MASK  RW
//     0xC EDGE_CFG  RW   [7:0] rise enables, [15:8] fall enables
//   The fields are packed into 8-bit slots, so WIDTH must not exceed 8.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// gpio_in_cond_lane
//   One input bit: 2-flop synchroniser, debounce counter, held level.
//   rise_o/fall_o pulse combinationally in the cycle before the level
//   register changes, so the parent can latch the event on the same edge
//   that updates the level.
//
//   Ports
//     clk      in   1  system clock
//     rst      in   1  asynchronous active-high reset
//     pin_i    in   1  raw pad input
//     level_o  out  1  debounced level
//     rise_o   out  1  level goes 0->1 at the next edge
//     fall_o   out  1  level goes 1->0 at the next edge
// ---------------------------------------------------------------------------
module gpio_in_cond_lane #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // One spare bit so DB_CYCLES-1 always fits, including DB_CYCLES=1.
    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter restarts whenever the synced input agrees with the held
    // level, so any glitch shorter than DB_CYCLES leaves the level alone.
    // It is cleared on acceptance and never runs past CNT_LAST.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= pin_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  =  level_d & ~level_q;
    assign fall_o  = ~level_d &  level_q;

endmodule

module gpio_in_cond #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [15:0]      addr,
    input  logic [15:0]      wdata,
    input  logic             we,
    output logic [15:0]      rdata,
    output logic [WIDTH-1:0] gpio_in,
    output logic             irq
);

    localparam logic [3:0] OFF_LEVEL  = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_MASK   = 4'h8;
    localparam logic [3:0] OFF_EDGE   = 4'hC;

    typedef struct packed {
        logic [3:0]  off;
        logic [15:0] wdata;
        logic        we;
    } bus_req_t;

    bus_req_t req;
    assign req = '{off: addr[3:0], wdata: wdata, we: we};

    // Upper address bits are decoded outside this block.
    logic unused_addr;
    assign unused_addr = ^addr[15:4];

    logic [WIDTH-1:0] rise, fall;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] ev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        gpio_in_cond_lane #(
            .DB_CYCLES(DB_CYCLES)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .pin_i  (pins_in[i]),
            .level_o(gpio_in[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    // Register writes and event latching. Events are qualified with the
    // registered enables, so an edge landing on the same clock as an
    // EDGE_CFG write still sees the old enables. The event OR comes after
    // the W1C clear so a coincident event keeps its status bit set.
    always_comb begin
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (req.we) begin
            case (req.off)
                OFF_STATUS: w1c = req.wdata[WIDTH-1:0];
                OFF_MASK:   mask_d = req.wdata[WIDTH-1:0];
                OFF_EDGE: begin
                    rise_en_d = req.wdata[WIDTH-1:0];
                    fall_en_d = req.wdata[8 +: WIDTH];
                end
                default: ;
            endcase
        end
        ev       = (rise & rise_en_q) | (fall & fall_en_q);
        status_d = (status_q & ~w1c) | ev;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q  <= '0;
            mask_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else begin
            status_q  <= status_d;
            mask_q    <= mask_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (req.off)
            OFF_LEVEL:  rdata[WIDTH-1:0] = gpio_in;
            OFF_STATUS: rdata[WIDTH-1:0] = status_q;
            OFF_MASK:   rdata[WIDTH-1:0] = mask_q;
            OFF_EDGE: begin
                rdata[WIDTH-1:0]  = rise_en_q;
                rdata[8 +: WIDTH] = fall_en_q;
            end
            default: ;
        endcase
    end

    assign irq = |(status_q & mask_q);

endmodule

// File: tb/tb_gpio_in_cond.sv
module tb_gpio_in_cond;

    localparam int LVL = 0;
    localparam int IRQ = 1;
    localparam int RD  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pins;
    logic [15:0] addr, wdata, rdata;
    logic        we;
    logic [7:0]  gpio_in;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] a;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    gpio_in_cond #(.WIDTH(8), .DB_CYCLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .pins_in(pins),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .rdata  (rdata),
        .gpio_in(gpio_in),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [15:0] a, input logic [15:0] e);
        exp_t x;
        x.tag = tag; x.sel = sel; x.a = a; x.exp = e;
        sb.push_back(x);
    endtask

    // Pop every pending expectation and compare it with what the DUT shows now.
    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.sel)
                LVL: chk(x.tag, {8'h00, gpio_in}, x.exp);
                IRQ: chk(x.tag, {15'h0000, irq}, x.exp);
                default: begin
                    addr = x.a;
                    we   = 1'b0;
                    #1;
                    chk(x.tag, rdata, x.exp);
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        wdata = 16'h0000;
    endtask

    initial begin
        rst = 1'b1; pins = 8'h00; addr = 16'h0000; wdata = 16'h0000; we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push("rst_level", LVL, 16'h0, 16'h0000);
        push("rst_irq",   IRQ, 16'h0, 16'h0000);
        drain();
        rst = 1'b0;
        tick();
        push("rst_rd0", RD, 16'h0, 16'h0000);
        push("rst_rd4", RD, 16'h4, 16'h0000);
        push("rst_rd8", RD, 16'h8, 16'h0000);
        push("rst_rdC", RD, 16'hC, 16'h0000);
        drain();

        // Debounce latency: level must appear at edge k+5, not k+4.
        pins = 8'h01;
        repeat (5) tick();
        push("lat_k4", LVL, 16'h0, 16'h0000);
        drain();
        tick();
        push("lat_k5", LVL, 16'h0, 16'h0001);
        drain();

        // Three-cycle glitch on bit 1 is rejected.
        pins = 8'h03;
        repeat (3) tick();
        pins = 8'h01;
        repeat (8) tick();
        push("glitch_lvl",  LVL, 16'h0, 16'h0001);
        push("glitch_stat", RD,  16'h4, 16'h0000);
        drain();

        // Writes to LEVEL and unmapped offsets are ignored.
        wr(16'h0000, 16'hFFFF);
        wr(16'h0006, 16'hFFFF);
        push("ro_level", RD, 16'h0, 16'h0001);
        push("unmapped", RD, 16'h6, 16'h0000);
        push("ro_mask",  RD, 16'h8, 16'h0000);
        push("ro_stat",  RD, 16'h4, 16'h0000);
        drain();

        // Rising event on bit 2 with interrupt enabled, then W1C.
        wr(16'h000C, 16'h0004);
        wr(16'h0008, 16'h0004);
        push("cfg_rb",  RD,  16'hC, 16'h0004);
        push("mask_rb", RD,  16'h8, 16'h0004);
        push("irq_pre", IRQ, 16'h0, 16'h0000);
        drain();
        pins = 8'h05;
        repeat (5) tick();
        push("rise_k4_lvl", LVL, 16'h0, 16'h0001);
        push("rise_k4_irq", IRQ, 16'h0, 16'h0000);
        drain();
        tick();
        push("rise_lvl",  LVL, 16'h0, 16'h0005);
        push("rise_stat", RD,  16'h4, 16'h0004);
        push("rise_irq",  IRQ, 16'h0, 16'h0001);
        drain();
        wr(16'h0004, 16'h0004);
        push("w1c_irq",  IRQ, 16'h0, 16'h0000);
        push("w1c_stat", RD,  16'h4, 16'h0000);
        drain();

        // Falling event, then mask toggling gates irq without touching status.
        wr(16'h000C, 16'h0404);
        pins = 8'h01;
        repeat (6) tick();
        push("fall_stat", RD,  16'h4, 16'h0004);
        push("fall_irq",  IRQ, 16'h0, 16'h0001);
        drain();
        wr(16'h0008, 16'h0000);
        push("mask0_irq",  IRQ, 16'h0, 16'h0000);
        push("mask0_stat", RD,  16'h4, 16'h0004);
        drain();
        wr(16'h0008, 16'h0004);
        push("mask1_irq", IRQ, 16'h0, 16'h0001);
        drain();
        wr(16'h0004, 16'h0004);
        push("clr2_stat", RD, 16'h4, 16'h0000);
        drain();

        // Event and W1C on the same edge: set wins.
        pins = 8'h05;
        repeat (5) tick();
        wr(16'h0004, 16'h0004);
        push("coinc_lvl",  LVL, 16'h0, 16'h0005);
        push("coinc_stat", RD,  16'h4, 16'h0004);
        drain();
        wr(16'h0004, 16'h0004);
        push("coinc_clr", RD, 16'h4, 16'h0000);
        drain();

        // Edge coincident with EDGE_CFG write uses the old enables.
        pins = 8'h01;
        repeat (5) tick();
        wr(16'h000C, 16'h0004);
        push("oldcfg_on_stat", RD, 16'h4, 16'h0004);
        push("oldcfg_on_cfg",  RD, 16'hC, 16'h0004);
        drain();
        wr(16'h0004, 16'h0004);
        wr(16'h000C, 16'h0000);
        pins = 8'h05;
        repeat (5) tick();
        wr(16'h000C, 16'h0004);
        push("oldcfg_off_lvl",  LVL, 16'h0, 16'h0005);
        push("oldcfg_off_stat", RD,  16'h4, 16'h0000);
        drain();

        // Reset while bit 3 is mid-debounce (cnt=2).
        pins = 8'h0D;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        push("mid_rst_lvl", LVL, 16'h0, 16'h0000);
        push("mid_rst_irq", IRQ, 16'h0, 16'h0000);
        drain();
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        push("requal_k4", LVL, 16'h0, 16'h0000);
        drain();
        tick();
        push("requal_k5",   LVL, 16'h0, 16'h000D);
        push("requal_stat", RD,  16'h4, 16'h0000);
        push("requal_cfg",  RD,  16'hC, 16'h0000);
        push("requal_irq",  IRQ, 16'h0, 16'h0000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
